// File: rtl/slot_fifo_pkg.sv
// Shared sizing and pointer helpers for the slot FIFO (slot_fifo_ctrl, slot_fifo_dv).
package slot_fifo_pkg;

   function automatic int ptr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

   // Explicit wrap so depths that are not a power of two still cycle correctly.
   function automatic int unsigned ptr_wrap(input int unsigned p, input int unsigned n);
      return (p == n - 1) ? 0 : p + 1;
   endfunction

endpackage

// File: rtl/slot_fifo_ctrl.sv
// Dataless control of the slot FIFO: head/tail pointers, full/empty flags and,
// with SLOT_FIFO_DV_COUNT_EN, a registered occupancy counter.
module slot_fifo_ctrl
   import slot_fifo_pkg::*;
#(
   parameter int NUM_SLOTS = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                ins_valid,
   input  logic                                outs_ready,
   output logic                                ins_ready,
   output logic                                outs_valid,
   output logic                                wr_en,
   output logic [ptr_width(NUM_SLOTS)-1:0]     head_idx,
   output logic [ptr_width(NUM_SLOTS)-1:0]     tail_idx
`ifdef SLOT_FIFO_DV_COUNT_EN
   ,
   output logic [count_width(NUM_SLOTS)-1:0]   count
`endif
);

   localparam int PW = ptr_width(NUM_SLOTS);

   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW-1:0] head_nxt, tail_nxt;
   logic          full_q, full_d, empty_q, empty_d;
   logic          rd_en;

   // Handshake outputs come from flops only, so outs_ready never reaches ins_ready.
   assign ins_ready  = ~full_q;
   assign outs_valid = ~empty_q;
   assign wr_en      = ins_valid & ~full_q;
   assign rd_en      = outs_ready & ~empty_q;
   assign head_idx   = head_q;
   assign tail_idx   = tail_q;

   assign head_nxt = PW'(ptr_wrap(32'(head_q), NUM_SLOTS));
   assign tail_nxt = PW'(ptr_wrap(32'(tail_q), NUM_SLOTS));

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      full_d  = full_q;
      empty_d = empty_q;
      case ({wr_en, rd_en})
         2'b10: begin
            tail_d  = tail_nxt;
            empty_d = 1'b0;
            full_d  = (tail_nxt == head_q);
         end
         2'b01: begin
            head_d  = head_nxt;
            full_d  = 1'b0;
            empty_d = (head_nxt == tail_q);
         end
         2'b11: begin
            head_d = head_nxt;
            tail_d = tail_nxt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

`ifdef SLOT_FIFO_DV_COUNT_EN
   localparam int CW = count_width(NUM_SLOTS);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (wr_en && !rd_en)      count_d = count_q + CW'(1);
      else if (!wr_en && rd_en) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count_q <= '0;
      else      count_q <= count_d;
   end

   assign count = count_q;
`endif

endmodule

// File: rtl/slot_fifo_dv.sv
// Multi-slot elastic FIFO with registered valid/data; optional occupancy port
// enabled by SLOT_FIFO_DV_COUNT_EN.
module slot_fifo_dv
   import slot_fifo_pkg::*;
#(
   parameter int DATA_TYPE = 32,
   parameter int NUM_SLOTS = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [DATA_TYPE-1:0]                ins,
   input  logic                                ins_valid,
   output logic                                ins_ready,
   output logic [DATA_TYPE-1:0]                outs,
   output logic                                outs_valid,
   input  logic                                outs_ready
`ifdef SLOT_FIFO_DV_COUNT_EN
   ,
   output logic [count_width(NUM_SLOTS)-1:0]   count
`endif
);

   localparam int PW = ptr_width(NUM_SLOTS);

   logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
   logic                 wr_en;
   logic [PW-1:0]        head_idx, tail_idx;

   slot_fifo_ctrl #(
      .NUM_SLOTS (NUM_SLOTS)
   ) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (ins_valid),
      .outs_ready (outs_ready),
      .ins_ready  (ins_ready),
      .outs_valid (outs_valid),
      .wr_en      (wr_en),
      .head_idx   (head_idx),
      .tail_idx   (tail_idx)
`ifdef SLOT_FIFO_DV_COUNT_EN
      ,
      .count      (count)
`endif
   );

   // Storage is deliberately not reset; empty slots hold don't-care data.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[tail_idx] <= ins;
   end

   assign outs = mem_q[head_idx];

endmodule

// File: tb/tb_slot_fifo_dv.sv
// Scoreboard bench for slot_fifo_dv: a 4-slot instance for directed tests and a
// 3-slot instance for non-power-of-two wrap.
// Handshake: a token moves on a rising edge where valid and ready are both high.
module tb_slot_fifo_dv;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [31:0] ins4 = '0, outs4, ins3 = '0, outs3;
   logic        ins_valid4 = 1'b0, ins_ready4, outs_valid4, outs_ready4 = 1'b0;
   logic        ins_valid3 = 1'b0, ins_ready3, outs_valid3, outs_ready3 = 1'b0;
`ifdef SLOT_FIFO_DV_COUNT_EN
   logic [2:0]  count4;
   logic [1:0]  count3;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] exp4_q[$];
   logic [31:0] exp3_q[$];
   int          m4 = 0, m3 = 0;
   bit          wr4 = 0, rd4 = 0, wr3 = 0, rd3 = 0;

   always #5 clk = ~clk;

   slot_fifo_dv #(.DATA_TYPE(32), .NUM_SLOTS(4)) dut4 (
      .clk(clk), .rst(rst), .ins(ins4), .ins_valid(ins_valid4), .ins_ready(ins_ready4),
      .outs(outs4), .outs_valid(outs_valid4), .outs_ready(outs_ready4)
`ifdef SLOT_FIFO_DV_COUNT_EN
      , .count(count4)
`endif
   );

   slot_fifo_dv #(.DATA_TYPE(32), .NUM_SLOTS(3)) dut3 (
      .clk(clk), .rst(rst), .ins(ins3), .ins_valid(ins_valid3), .ins_ready(ins_ready3),
      .outs(outs3), .outs_valid(outs_valid3), .outs_ready(outs_ready3)
`ifdef SLOT_FIFO_DV_COUNT_EN
      , .count(count3)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard for the 4-slot instance: occupancy model decides acceptance.
   always @(negedge clk) begin
      if (!rst) begin
         check("rst4_outs_valid", 32'(outs_valid4), 32'd0);
         check("rst4_ins_ready", 32'(ins_ready4), 32'd1);
`ifdef SLOT_FIFO_DV_COUNT_EN
         check("rst4_count", 32'(count4), 32'd0);
`endif
         exp4_q.delete();
         m4 = 0; wr4 = 0; rd4 = 0;
      end else begin
         check("ins_ready4", 32'(ins_ready4), 32'(m4 < 4));
         check("outs_valid4", 32'(outs_valid4), 32'(m4 > 0));
`ifdef SLOT_FIFO_DV_COUNT_EN
         check("count4", 32'(count4), 32'(m4));
`endif
         if (m4 > 0) check("outs4", outs4, exp4_q[0]);
         wr4 = ins_valid4 && (m4 < 4);
         rd4 = outs_ready4 && (m4 > 0);
         if (rd4) void'(exp4_q.pop_front());
         if (wr4) exp4_q.push_back(ins4);
         m4 = m4 + int'(wr4) - int'(rd4);
      end
   end

   // Scoreboard for the 3-slot instance.
   always @(negedge clk) begin
      if (!rst) begin
         check("rst3_outs_valid", 32'(outs_valid3), 32'd0);
         exp3_q.delete();
         m3 = 0; wr3 = 0; rd3 = 0;
      end else begin
         check("ins_ready3", 32'(ins_ready3), 32'(m3 < 3));
         check("outs_valid3", 32'(outs_valid3), 32'(m3 > 0));
`ifdef SLOT_FIFO_DV_COUNT_EN
         check("count3", 32'(count3), 32'(m3));
`endif
         if (m3 > 0) check("outs3", outs3, exp3_q[0]);
         wr3 = ins_valid3 && (m3 < 3);
         rd3 = outs_ready3 && (m3 > 0);
         if (rd3) void'(exp3_q.pop_front());
         if (wr3) exp3_q.push_back(ins3);
         m3 = m3 + int'(wr3) - int'(rd3);
      end
   end

   // Offer one token to the 4-slot instance and hold it until accepted.
   task automatic send4(input logic [31:0] d, input int budget);
      int n = 0;
      ins4 = d;
      ins_valid4 = 1'b1;
      do begin
         @(posedge clk);
         n++;
      end while (!wr4 && n < budget);
      vectors++;
      if (!wr4) begin
         miscompares++;
         $display("FAIL send4_timeout: token 0x%0h not accepted after %0d cycles", d, n);
      end
      #1 ins_valid4 = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held with a pending token: nothing may be accepted.
      ins4 = 32'hDEAD;
      ins_valid4 = 1'b1;
      cycles(3);
      ins4 = 32'hA5;
      rst = 1'b1;
      send4(32'hA5, 5);
      check("first_latency_valid", 32'(outs_valid4), 32'd1);
      check("first_latency_data", outs4, 32'hA5);
      outs_ready4 = 1'b1;
      cycles(2);

      // Fill with the consumer stalled, then drain in order.
      outs_ready4 = 1'b0;
      for (int i = 1; i <= 4; i++) send4(32'(i), 5);
      check("fill_ins_ready", 32'(ins_ready4), 32'd0);
      ins4 = 32'd5;
      ins_valid4 = 1'b1;
      cycles(3);
      outs_ready4 = 1'b1;
      send4(32'd5, 10);
      cycles(8);

      // Full-rate streaming.
      for (int i = 0; i < 100; i++) send4(32'(1000 + i), 2);
      cycles(4);

      // Simultaneous read and write at occupancy two.
      outs_ready4 = 1'b0;
      send4(32'd200, 5);
      send4(32'd201, 5);
      outs_ready4 = 1'b1;
      send4(32'd202, 2);
      outs_ready4 = 1'b0;
      check("simul_head", outs4, 32'd201);
      cycles(2);
      outs_ready4 = 1'b1;
      cycles(4);

      // Asynchronous reset with three tokens stored.
      outs_ready4 = 1'b0;
      send4(32'd300, 5);
      send4(32'd301, 5);
      send4(32'd302, 5);
      rst = 1'b0;
      #1;
      check("async_rst_outs_valid", 32'(outs_valid4), 32'd0);
      check("async_rst_ins_ready", 32'(ins_ready4), 32'd1);
`ifdef SLOT_FIFO_DV_COUNT_EN
      check("async_rst_count", 32'(count4), 32'd0);
`endif
      cycles(2);
      rst = 1'b1;
      send4(32'h7, 5);
      check("post_rst_data", outs4, 32'h7);
      outs_ready4 = 1'b1;
      cycles(3);

      // Non-power-of-two depth under random valid/ready; data steps only on acceptance.
      ins3 = 32'h100;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk);
         #1;
         if (wr3) ins3 = ins3 + 32'd1;
         if (!ins_valid3 || wr3) ins_valid3 = 1'($urandom_range(0, 1));
         outs_ready3 = 1'($urandom_range(0, 3) != 0 ? (c % 50 < 25) : 1);
      end
      ins_valid3 = 1'b0;
      outs_ready3 = 1'b1;
      cycles(8);
      check("final_occ3", 32'(outs_valid3), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
